// File: rtl/pfd_loop_filter.sv
// Digital charge pump + PI loop filter: measures synchronized PFD up/dn pulse widths, updates a DCO word.
// Latency: ctrl_out/ctrl_valid two cycles after synchronized up/dn both fall; no backpressure (strobe only).
// Backpressure: none; ctrl_valid is a one-cycle strobe and the consumer must take it.
module pfd_loop_filter #(
    parameter int CTRL_W    = 12,
    parameter int INT_W     = 20,
    parameter int CTRL_INIT = 2048,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 6,
    parameter int TIMEOUT   = 4095,
    parameter int LOCK_WIN  = 2,
    parameter int LOCK_CNT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              locked,
    output logic              sat
);

    localparam int ERR_W = 13;
    localparam int SUM_W = INT_W + 2;
    localparam int GC_W  = $clog2(LOCK_CNT + 1);

    localparam logic signed [INT_W:0]   INT_MAX  = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W:0]   INT_MIN  = {2'b11, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] INIT_S   = SUM_W'(CTRL_INIT);
    localparam logic signed [SUM_W-1:0] CTRL_MAX = SUM_W'((1 << CTRL_W) - 1);
    localparam logic [11:0]             TMO      = 12'(TIMEOUT);
    localparam logic [GC_W-1:0]         GC_MAX   = GC_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]        WIN      = ERR_W'(LOCK_WIN);

    typedef enum logic [1:0] {IDLE, MEASURE, UPDATE} state_t;

    state_t                    state, state_n;
    logic                      up_s1, up_s2, dn_s1, dn_s2;
    logic                      u, d;
    logic signed [ERR_W-1:0]   err, inc;
    logic [11:0]               tcnt;
    logic                      to_flag;
    logic signed [INT_W-1:0]   integ, integ_n;
    logic signed [INT_W:0]     integ_wide;
    logic signed [ERR_W-1:0]   p_term;
    logic signed [INT_W-1:0]   i_term;
    logic signed [SUM_W-1:0]   sum;
    logic [CTRL_W-1:0]         ctrl_n;
    logic                      sat_n;
    logic [ERR_W-1:0]          err_abs;
    logic                      in_win;
    logic [GC_W-1:0]           good_cnt, good_n;

    assign u = up_s2;
    assign d = dn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_s1 <= 1'b0;
            up_s2 <= 1'b0;
            dn_s1 <= 1'b0;
            dn_s2 <= 1'b0;
        end else begin
            up_s1 <= up;
            up_s2 <= up_s1;
            dn_s1 <= dn;
            dn_s2 <= dn_s1;
        end
    end

    always_comb begin
        inc = '0;
        if (u && !d)
            inc = 13'sd1;
        else if (d && !u)
            inc = -13'sd1;
    end

    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (u || d) state_n = MEASURE;
                MEASURE: if (!u && !d) state_n = UPDATE;
                         else if (tcnt == TMO) state_n = UPDATE;
                UPDATE:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Update datapath: saturating integrator, then PI sum clamped to the DCO code range.
    always_comb begin
        integ_wide = {integ[INT_W-1], integ} + {{(INT_W+1-ERR_W){err[ERR_W-1]}}, err};
        if (integ_wide > INT_MAX)
            integ_n = INT_MAX[INT_W-1:0];
        else if (integ_wide < INT_MIN)
            integ_n = INT_MIN[INT_W-1:0];
        else
            integ_n = integ_wide[INT_W-1:0];

        p_term = err >>> KP_SHIFT;
        i_term = integ_n >>> KI_SHIFT;
        sum    = INIT_S
               + {{(SUM_W-ERR_W){p_term[ERR_W-1]}}, p_term}
               + {{2{i_term[INT_W-1]}}, i_term};

        ctrl_n = sum[CTRL_W-1:0];
        sat_n  = 1'b0;
        if (sum[SUM_W-1]) begin
            ctrl_n = '0;
            sat_n  = 1'b1;
        end else if (sum > CTRL_MAX) begin
            ctrl_n = '1;
            sat_n  = 1'b1;
        end

        err_abs = err[ERR_W-1] ? -err : err;
        in_win  = (err_abs <= WIN) && !to_flag;
        good_n  = (good_cnt == GC_MAX) ? GC_MAX : good_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            err        <= '0;
            tcnt       <= '0;
            to_flag    <= 1'b0;
            integ      <= '0;
            good_cnt   <= '0;
            ctrl_out   <= CTRL_W'(CTRL_INIT);
            ctrl_valid <= 1'b0;
            locked     <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state      <= state_n;
            ctrl_valid <= 1'b0;
            if (!en) begin
                err      <= '0;
                tcnt     <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (u || d) begin
                            err     <= inc;
                            tcnt    <= 12'd1;
                            to_flag <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (u || d) begin
                            if (tcnt == TMO) begin
                                to_flag <= 1'b1;
                            end else begin
                                err  <= err + inc;
                                tcnt <= tcnt + 12'd1;
                            end
                        end
                    end
                    UPDATE: begin
                        integ      <= integ_n;
                        ctrl_out   <= ctrl_n;
                        sat        <= sat_n;
                        ctrl_valid <= 1'b1;
                        if (in_win) begin
                            good_cnt <= good_n;
                            locked   <= (good_n == GC_MAX);
                        end else begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Scoreboard bench for pfd_loop_filter: a PI model predicts each update, a negedge monitor checks every strobe.
module tb_pfd_loop_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        dn;
    logic [11:0] ctrl_out;
    logic        ctrl_valid;
    logic        locked;
    logic        sat;

    pfd_loop_filter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .dn         (dn),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .locked     (locked),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ctrl;
        int sat;
        int lck;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_integ, m_good, m_ctrl;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && ctrl_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ctrl_out", int'(ctrl_out), e.ctrl);
                chk("sat", int'(sat), e.sat);
                chk("locked", int'(locked), e.lck);
                if (e.cyc >= 0)
                    chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic model_reset();
        m_integ = 0;
        m_good  = 0;
        m_ctrl  = 2048;
    endtask

    task automatic model_upd(input int err, input bit to, input int exp_cyc);
        exp_t e;
        int   s;
        m_integ = m_integ + err;
        if (m_integ > 524287)  m_integ = 524287;
        if (m_integ < -524288) m_integ = -524288;
        s = 2048 + (err >>> 2) + (m_integ >>> 6);
        e.sat = 0;
        if (s < 0)    begin s = 0;    e.sat = 1; end
        if (s > 4095) begin s = 4095; e.sat = 1; end
        m_ctrl = s;
        if ((err <= 2) && (err >= -2) && !to)
            m_good = (m_good < 64) ? m_good + 1 : 64;
        else
            m_good = 0;
        e.ctrl = s;
        e.lck  = (m_good == 64) ? 1 : 0;
        e.cyc  = exp_cyc;
        q.push_back(e);
    endtask

    // up high nu cycles and dn high nd cycles, both starting on the same edge.
    task automatic pulse(input int nu, input int nd, input bit expect_upd);
        int n;
        n = (nu > nd) ? nu : nd;
        @(negedge clk);
        up = (nu > 0);
        dn = (nd > 0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == nu) up = 1'b0;
            if (i == nd) dn = 1'b0;
        end
        if (expect_upd)
            model_upd(nu - nd, 1'b0, cyc + 4);
        repeat (8) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", (q.size() == 0) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, int'(ctrl_out), 2048);
        chk({tag, "_valid"}, int'(ctrl_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_sat"}, int'(sat), 0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        up  = 1'b0;
        dn  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pulse(8, 0, 1'b1);
        pulse(0, 8, 1'b1);

        for (int i = 0; i < 64; i++)
            pulse(3, 3, 1'b1);
        pulse(8, 3, 1'b1);
        drain(100);

        @(negedge clk);
        en = 1'b0;
        m_good = 0;
        pulse(10, 0, 1'b0);
        chk("en_hold_ctrl", int'(ctrl_out), m_ctrl);
        chk("en_locked", int'(locked), 0);
        en = 1'b1;
        pulse(4, 0, 1'b1);
        drain(100);

        @(negedge clk);
        up = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        up  = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 17; i++)
            model_upd(4095, 1'b1, -1);
        up = 1'b1;
        drain(17 * 4200);
        @(negedge clk);
        rst = 1'b1;
        up  = 1'b0;
        #1;
        chk_reset_vals("rst_end");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfd_loop_filter.md
Name: pfd_loop_filter

Overview:
- Consumer end of the PFD up/dn interface: a digital charge pump plus PI loop filter for the PLL.
- Samples the asynchronous up/dn pulses on a fast sampling clock and measures each pulse as a signed width in clk cycles.
- Updates a saturating integrator once per comparison and drives a proportional+integral DCO control word with a valid strobe.
- Includes a lock detector that counts consecutive small-error comparisons.

Parameters:
CTRL_W, 12, width of DCO control word ctrl_out (unsigned)
INT_W, 20, width of signed integrator accumulator
CTRL_INIT, 2048, control word after reset (DCO centre code)
KP_SHIFT, 2, proportional gain = err >>> KP_SHIFT
KI_SHIFT, 6, integral gain = integ >>> KI_SHIFT
TIMEOUT, 4095, max MEASURE length in clk cycles; must be < 2^12
LOCK_WIN, 2, max |err| counted as an in-lock comparison
LOCK_CNT, 64, consecutive in-window comparisons required to assert locked

Ports:
clk  in  1  sampling clock; must be much faster than the PFD ref clock
rst  in  1  reset, asynchronous, active-high
en  in  1  loop enable; low = freeze the loop
up  in  1  PFD up pulse, asynchronous to clk
dn  in  1  PFD dn pulse, asynchronous to clk
ctrl_out  out  CTRL_W  DCO control word
ctrl_valid  out  1  one-cycle strobe when ctrl_out has been updated
locked  out  1  lock indicator
sat  out  1  last ctrl_out computation was clamped

Behaviour:
Reset (async, takes effect immediately, including mid-MEASURE):
- ctrl_out=CTRL_INIT, ctrl_valid=0, locked=0, sat=0.
- integ=0, err=0, good_cnt=0, timeout counter=0, state=IDLE, synchronizer flops=0.

Input synchronization:
- up and dn each pass through a 2-flop synchronizer, producing u and d.
- All logic below uses only u and d.

Per-cycle increment inc:
- +1 if u&~d; -1 if d&~u; 0 if both high (PFD reset overlap) or both low.

Error register err:
- 13-bit signed.
- Cannot overflow because MEASURE is capped at TIMEOUT cycles.

FSM, three states:
- IDLE: if en&(u|d), go to MEASURE with err<=inc and tcnt<=1, so the first high cycle is counted. Otherwise stay in IDLE.
- MEASURE:
  - If ~u&~d, go to UPDATE.
  - Else if tcnt==TIMEOUT, go to UPDATE with to_flag=1 (stuck pulse).
  - Else err<=err+inc, tcnt<=tcnt+1.
- UPDATE (one cycle), then return to IDLE:
  - integ_n = integ + sign-extended err, saturated to the INT_W signed range; integ<=integ_n.
  - sum = CTRL_INIT + (err >>> KP_SHIFT) + (integ_n >>> KI_SHIFT), computed in INT_W+2 signed bits.
  - Clamp sum to [0, 2^CTRL_W-1] and register it into ctrl_out. sat<=1 if clamped, else 0.
  - ctrl_valid is high for exactly the cycle following UPDATE; ctrl_out changes on that same edge.
  - Latency: synchronized u/d both low at edge N → UPDATE in cycle N+1 → ctrl_out/ctrl_valid visible from N+2.

Lock detector (evaluated in UPDATE):
- If |err|<=LOCK_WIN and ~to_flag: good_cnt<=min(good_cnt+1, LOCK_CNT); locked<=1 when the new value equals LOCK_CNT.
- Otherwise good_cnt<=0 and locked<=0.

Enable:
- en=0 forces state to IDLE and clears err, tcnt and good_cnt, and drives locked=0.
- ctrl_out, integ and sat hold their values; no ctrl_valid is issued.
- en deasserted during MEASURE aborts the measurement with no update.

Continuous pulse:
- If u or d is still high after a timeout UPDATE, IDLE immediately starts a new MEASURE.

Test Plan:
- Reset check: assert rst → ctrl_out=2048, ctrl_valid=0, locked=0, sat=0. Assert rst mid-MEASURE → same values immediately, no ctrl_valid.
- up high for 8 synchronized cycles, dn low → err=+8, integ=8, ctrl_out=2048+2+0=2050, ctrl_valid high for exactly 1 cycle, 2 cycles after u falls.
- From the previous state, dn high for 8 cycles → err=-8, integ=0, ctrl_out=2046, sat=0.
- 64 comparisons, each with up and dn high simultaneously for 3 cycles (err=0) → locked rises at the 64th ctrl_valid. Next comparison with up 5 cycles longer than dn (err=+5) → locked=0, good_cnt=0.
- up held high continuously → an UPDATE every 4095 cycles with err=4095 and locked staying 0. Updates 1..16 give ctrl_out 3134…4094 with sat=0; update 17 gives ctrl_out=4095, sat=1.
- en=0 while up pulses for 10 cycles → no ctrl_valid, ctrl_out and integ unchanged, locked=0. Re-enable and pulse up for 4 cycles → ctrl_out updates normally with err=+4.
